pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Generic, parametrised pipeline stage register that replaces the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one elastic block.
- Carries a control field, which is zeroed on flush or bubble, and a data field, which holds its value on flush.
- Uses a valid/ready handshake with an optional skid entry, so back-pressure from a later stage stalls the pipe without losing full throughput.
- Counts entries discarded by flush, for hazard-unit debug.

Parameters:
- CWIDTH, 16: control field width (WB/MEM/EX control bits, instruction word); cleared on flush.
- DWIDTH, 128: data field width (register data, immediate, PC+4, addresses); not cleared on flush.
- SKID, 1: 1 = two-entry skid buffer, with inready fully registered; 0 = single register, with inready = !outvalid | outready (combinational).
- CNTW, 8: width of the drop counter.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rstn, input, 1: asynchronous active-low reset.
- flush, input, 1: synchronous flush, active HIGH.
- invalid, input, 1: upstream entry valid.
- inready, output, 1: stage can accept an entry this cycle.
- inctl, input, CWIDTH: upstream control field.
- indata, input, DWIDTH: upstream data field.
- outvalid, output, 1: stage holds a valid entry.
- outready, input, 1: downstream accepts this cycle.
- outctl, output, CWIDTH: control field of the head entry.
- outdata, output, DWIDTH: data field of the head entry.
- dropcnt, output, CNTW: saturating count of valid entries discarded by flush.

Behaviour:
- Handshakes:
  - Input transfer (push) = invalid & inready.
  - Output transfer (pop) = outvalid & outready.
  - The producer must hold inctl/indata stable while invalid=1 and inready=0.
- Reset (rstn=0, asynchronous):
  - state=EMPTY, outvalid=0, outctl=0, outdata=0, dropcnt=0.
  - Skid registers are zeroed.
  - inready=1 once rstn is released, provided flush=0.
- Storage: main register (drives outctl/outdata) plus skid register (SKID=1 only).
- State machine for SKID=1:
  - EMPTY: push -> BUSY, main<=in.
  - BUSY, push and pop: stay BUSY, main<=in (one entry per cycle throughput).
  - BUSY, push only: -> FULL, skid<=in.
  - BUSY, pop only: -> EMPTY.
  - FULL: inready=0; pop -> BUSY, main<=skid; otherwise hold.
  - inready = (state!=FULL) & !flush. This depends only on registered state and flush.
- State machine for SKID=0:
  - No FULL state.
  - inready = (!outvalid | outready) & !flush.
  - Push -> main<=in, BUSY.
  - Pop without push -> EMPTY.
- outvalid = (state!=EMPTY). It is registered, with 1-cycle latency from push to outvalid.
- Bubble rule: whenever the state becomes EMPTY (by pop or flush), main ctl<=0 and main data holds. outctl is therefore 0 whenever outvalid=0.
- Flush (flush=1 at a clock edge):
  - Priority is above push and pop; reset still overrides flush.
  - No push is accepted in a flush cycle (inready forced 0).
  - A pop that occurs in the flush cycle completes normally and is not counted as a drop.
  - Next state=EMPTY; outvalid<=0; main ctl and skid ctl <=0; data fields hold.
  - Drop count: dropcnt += number of valid entries not popped this cycle (0, 1 or 2), saturating at all-ones.
- Flush held for multiple cycles: the stage stays EMPTY with inready=0, and dropcnt does not increase.
- Reset during FULL or mid-handshake: all entries are lost immediately; outputs go to their reset values asynchronously.
- Widths: no arithmetic except dropcnt, which saturates with no wrap-around.
- Latency: push to head is 1 cycle when the stage is EMPTY or popping. An entry taken into the skid register appears at the head 1 cycle after the next pop.

Test Plan:
- Streaming: SKID=1; push ctl=1..8 over 8 consecutive cycles with outready=1 -> outvalid rises 1 cycle after the first push; outctl=1..8 on consecutive cycles; inready stays 1; dropcnt=0.
- Back-pressure: SKID=1; push A(ctl=0xA,data=0x11) then B(ctl=0xB,data=0x22) with outready=0 -> state FULL, inready=0; raising outready pops A then B in order with no duplication or loss.
- Flush with drops: FULL with A and B, flush=1, outready=0 -> next cycle outvalid=0, outctl=0, outdata=0x11 held, dropcnt=2. Repeat with outready=1 -> dropcnt increases by 1 only.
- Flush/push collision: EMPTY, invalid=1 and flush=1 in the same cycle -> inready=0; the entry is not captured; outvalid stays 0.
- SKID=0 stall: outvalid=1, outready=0 -> inready=0. Assert outready with invalid=1 (ctl=0x5) -> pop and push occur in the same cycle; next outctl=0x5.
- Reset mid-operation plus saturation: CNTW=2; drop 5 entries via flush -> dropcnt=3. Pull rstn low while FULL -> outvalid=0, dropcnt=0, and inready=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register: valid/ready handshake, optional skid entry,
// control field bubbled to zero on flush/empty, saturating flush-drop counter.
module pipe_stage_reg #(
  parameter int CWIDTH = 16,
  parameter int DWIDTH = 128,
  parameter int SKID   = 1,
  parameter int CNTW   = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              invalid,
  output logic              inready,
  input  logic [CWIDTH-1:0] inctl,
  input  logic [DWIDTH-1:0] indata,
  output logic              outvalid,
  input  logic              outready,
  output logic [CWIDTH-1:0] outctl,
  output logic [DWIDTH-1:0] outdata,
  output logic [CNTW-1:0]   dropcnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MAIN_HOLD,
    MAIN_IN,
    MAIN_SKID,
    MAIN_BUBBLE
  } main_op_t;

  state_t            state_q, state_d;
  main_op_t          main_op;
  logic [CWIDTH-1:0] skid_ctl_q;
  logic [DWIDTH-1:0] skid_data_q;
  logic              push, pop;
  logic              skid_ld, skid_clr;
  logic [1:0]        drops;
  logic [CNTW:0]     cnt_sum;

  assign outvalid = (state_q != EMPTY);

  // With a skid entry inready is a pure function of registered state and flush.
  generate
    if (SKID != 0) begin : g_skid
      assign inready = (state_q != FULL) & ~flush;
    end else begin : g_noskid
      assign inready = (~outvalid | outready) & ~flush;
    end
  endgenerate

  assign push = invalid & inready;
  assign pop  = outvalid & outready;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d  = state_q;
    main_op  = MAIN_HOLD;
    skid_ld  = 1'b0;
    skid_clr = 1'b0;
    drops    = 2'd0;
    if (flush) begin
      state_d  = EMPTY;
      main_op  = MAIN_BUBBLE;
      skid_clr = 1'b1;
      unique case (state_q)
        BUSY:    drops = pop ? 2'd0 : 2'd1;
        FULL:    drops = pop ? 2'd1 : 2'd2;
        default: drops = 2'd0;
      endcase
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (push) begin
            state_d = BUSY;
            main_op = MAIN_IN;
          end
        end
        BUSY: begin
          if (push && pop) begin
            main_op = MAIN_IN;
          end else if (push) begin
            state_d = FULL;
            skid_ld = 1'b1;
          end else if (pop) begin
            state_d = EMPTY;
            main_op = MAIN_BUBBLE;
          end
        end
        FULL: begin
          if (pop) begin
            state_d = BUSY;
            main_op = MAIN_SKID;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // One extra bit catches the carry out, which means saturate.
  assign cnt_sum = {1'b0, dropcnt} + (CNTW + 1)'(drops);

  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: the data fields are plain registers, not a memory, so they are reset with everything else.
    if (!rstn) begin
      state_q     <= EMPTY;
      outctl      <= '0;
      outdata     <= '0;
      skid_ctl_q  <= '0;
      skid_data_q <= '0;
      dropcnt     <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
      state_q <= state_d;

      unique case (main_op)
        MAIN_IN: begin
          outctl  <= inctl;
          outdata <= indata;
        end
        MAIN_SKID: begin
          outctl  <= skid_ctl_q;
          outdata <= skid_data_q;
        end
        MAIN_BUBBLE: outctl <= '0;
        default: ;
      endcase

      if (skid_clr) begin
        skid_ctl_q <= '0;
      end else if (skid_ld) begin
        skid_ctl_q  <= inctl;
        skid_data_q <= indata;
      end

      dropcnt <= cnt_sum[CNTW] ? {CNTW{1'b1}} : cnt_sum[CNTW-1:0];
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three configurations (skid, no skid, 2-bit counter),
// each checked by a FIFO reference model, an output scoreboard and directed spot checks.
module tb_pipe_stage_reg;

  localparam int NU = 3;

  typedef struct packed {
    logic [7:0]  c;
    logic [31:0] d;
  } ent_t;

  logic        clk;
  logic        rstn;
  logic        flush_a    [NU];
  logic        invalid_a  [NU];
  logic        inready_a  [NU];
  logic [7:0]  inctl_a    [NU];
  logic [31:0] indata_a   [NU];
  logic        outvalid_a [NU];
  logic        outready_a [NU];
  logic [7:0]  outctl_a   [NU];
  logic [31:0] outdata_a  [NU];
  logic [7:0]  dropcnt_a  [NU];

  int n_checks = 0;
  int n_pass   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  for (genvar g = 0; g < NU; g++) begin : gen_u
    localparam int SK   = (g == 1) ? 0 : 1;
    localparam int CW   = (g == 2) ? 2 : 8;
    localparam int DMAX = (1 << CW) - 1;

    logic [CW-1:0] dc;
    ent_t          sb[$];
    logic [31:0]   mq[$];
    logic [31:0]   held;
    int            drops;
    int            nd;
    bit            pop, acc;
    ent_t          e;

    pipe_stage_reg #(
      .CWIDTH(8),
      .DWIDTH(32),
      .SKID  (SK),
      .CNTW  (CW)
    ) u_dut (
      .clk     (clk),
      .rstn    (rstn),
      .flush   (flush_a[g]),
      .invalid (invalid_a[g]),
      .inready (inready_a[g]),
      .inctl   (inctl_a[g]),
      .indata  (indata_a[g]),
      .outvalid(outvalid_a[g]),
      .outready(outready_a[g]),
      .outctl  (outctl_a[g]),
      .outdata (outdata_a[g]),
      .dropcnt (dc)
    );

    assign dropcnt_a[g] = 8'(dc);

    // Capacity rule: two entries with a skid slot, else one entry that can be replaced while leaving.
    function automatic logic exp_rdy();
      if (flush_a[g]) return 1'b0;
      if (SK != 0) return mq.size() < 2;
      return (mq.size() == 0) || outready_a[g];
    endfunction

    always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        sb.delete();
        mq.delete();
        held  = '0;
        drops = 0;
      end else begin
        pop = (mq.size() != 0) && outready_a[g];
        if (flush_a[g]) begin
          nd    = mq.size() - int'(pop);
          drops = (drops + nd > DMAX) ? DMAX : drops + nd;
          repeat (nd) if (sb.size() != 0) void'(sb.pop_back());
          mq.delete();
        end else begin
          acc = invalid_a[g] && exp_rdy();
          if (pop) void'(mq.pop_front());
          if (acc) begin
            mq.push_back(indata_a[g]);
            e.c = inctl_a[g];
            e.d = indata_a[g];
            sb.push_back(e);
          end
        end
        if (mq.size() != 0) held = mq[0];
      end
    end

    always @(negedge clk) begin
      if (rstn) begin
        check($sformatf("u%0d outvalid", g), outvalid_a[g], mq.size() != 0);
        check($sformatf("u%0d inready", g), inready_a[g], exp_rdy());
        check($sformatf("u%0d dropcnt", g), dropcnt_a[g], drops);
        if (!outvalid_a[g]) begin
          check($sformatf("u%0d bubble outctl", g), outctl_a[g], 0);
          check($sformatf("u%0d held outdata", g), outdata_a[g], held);
        end
        if (outvalid_a[g] && outready_a[g]) begin
          if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL u%0d pop: got ctl %0h, expected no entry", g, outctl_a[g]);
          end else begin
            e = sb.pop_front();
            check($sformatf("u%0d pop ctl", g), outctl_a[g], e.c);
            check($sformatf("u%0d pop data", g), outdata_a[g], e.d);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  bit stall [NU];

  initial begin
    rstn = 1'b0;
    for (int k = 0; k < NU; k++) begin
      flush_a[k]    = 1'b0;
      invalid_a[k]  = 1'b0;
      outready_a[k] = 1'b0;
      inctl_a[k]    = '0;
      indata_a[k]   = '0;
    end
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NU; k++) begin
      check($sformatf("u%0d reset outvalid", k), outvalid_a[k], 0);
      check($sformatf("u%0d reset inready", k), inready_a[k], 1);
      check($sformatf("u%0d reset outctl", k), outctl_a[k], 0);
      check($sformatf("u%0d reset outdata", k), outdata_a[k], 0);
      check($sformatf("u%0d reset dropcnt", k), dropcnt_a[k], 0);
    end
    cyc();

    // Streaming ctl=1..8 with the consumer always ready.
    outready_a[0] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      invalid_a[0] = 1'b1;
      inctl_a[0]   = 8'(i);
      indata_a[0]  = $urandom;
      cyc();
      if (i == 1) begin
        check("stream first outvalid", outvalid_a[0], 1);
        check("stream first outctl", outctl_a[0], 1);
      end
      check("stream inready", inready_a[0], 1);
    end
    invalid_a[0] = 1'b0;
    cyc();
    cyc();
    outready_a[0] = 1'b0;
    check("stream dropcnt", dropcnt_a[0], 0);

    // Back-pressure fills the skid slot, then drains in order.
    invalid_a[0] = 1'b1; inctl_a[0] = 8'h0A; indata_a[0] = 32'h11; cyc();
    inctl_a[0] = 8'h0B; indata_a[0] = 32'h22; cyc();
    invalid_a[0] = 1'b0;
    check("full inready", inready_a[0], 0);
    check("full head ctl", outctl_a[0], 8'h0A);
    outready_a[0] = 1'b1;
    cyc();
    check("drain second ctl", outctl_a[0], 8'h0B);
    cyc();
    outready_a[0] = 1'b0;
    check("drained outvalid", outvalid_a[0], 0);
    check("drained outctl", outctl_a[0], 0);
    check("drained outdata", outdata_a[0], 32'h22);

    // Flush while FULL, without and with a simultaneous pop.
    for (int r = 0; r < 2; r++) begin
      invalid_a[0] = 1'b1; inctl_a[0] = 8'h0A; indata_a[0] = 32'h11; cyc();
      inctl_a[0] = 8'h0B; indata_a[0] = 32'h22; cyc();
      invalid_a[0]  = 1'b0;
      flush_a[0]    = 1'b1;
      outready_a[0] = (r == 1);
      cyc();
      flush_a[0]    = 1'b0;
      outready_a[0] = 1'b0;
      check("flush outvalid", outvalid_a[0], 0);
      check("flush outctl", outctl_a[0], 0);
      check("flush outdata", outdata_a[0], 32'h11);
      check("flush dropcnt", dropcnt_a[0], (r == 0) ? 2 : 3);
    end

    // Push colliding with a held flush is refused and drops nothing.
    invalid_a[0] = 1'b1; inctl_a[0] = 8'h33; indata_a[0] = 32'h33; flush_a[0] = 1'b1;
    #1 check("collision inready", inready_a[0], 0);
    cyc(); cyc(); cyc();
    invalid_a[0] = 1'b0;
    flush_a[0]   = 1'b0;
    check("collision outvalid", outvalid_a[0], 0);
    check("held flush dropcnt", dropcnt_a[0], 3);

    // Single-register stage: stall, then pop and push in the same cycle.
    invalid_a[1] = 1'b1; inctl_a[1] = 8'h44; indata_a[1] = $urandom; cyc();
    invalid_a[1] = 1'b0;
    check("noskid stall outvalid", outvalid_a[1], 1);
    check("noskid stall inready", inready_a[1], 0);
    outready_a[1] = 1'b1;
    invalid_a[1]  = 1'b1; inctl_a[1] = 8'h05; indata_a[1] = $urandom;
    #1 check("noskid pass inready", inready_a[1], 1);
    cyc();
    invalid_a[1]  = 1'b0;
    outready_a[1] = 1'b0;
    check("noskid next outctl", outctl_a[1], 8'h05);
    check("noskid next outvalid", outvalid_a[1], 1);
    outready_a[1] = 1'b1;
    cyc();
    outready_a[1] = 1'b0;

    // 2-bit drop counter saturates at 3.
    for (int i = 0; i < 5; i++) begin
      invalid_a[2] = 1'b1; inctl_a[2] = 8'($urandom); indata_a[2] = $urandom; cyc();
      invalid_a[2] = 1'b0;
      flush_a[2]   = 1'b1;
      cyc();
      flush_a[2] = 1'b0;
      check("sat dropcnt", dropcnt_a[2], (i + 1 > 3) ? 3 : i + 1);
    end

    // Random traffic on all stages; a stalled offer is held unchanged.
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      for (int k = 0; k < NU; k++) stall[k] = invalid_a[k] && !inready_a[k];
      cyc();
      for (int k = 0; k < NU; k++) begin
        if (!stall[k]) begin
          invalid_a[k] = ($urandom_range(0, 9) < 7);
          inctl_a[k]   = 8'($urandom);
          indata_a[k]  = $urandom;
        end
        outready_a[k] = ($urandom_range(0, 9) < 6);
        flush_a[k]    = ($urandom_range(0, 19) == 0);
      end
    end
    for (int k = 0; k < NU; k++) begin
      invalid_a[k]  = 1'b0;
      flush_a[k]    = 1'b0;
      outready_a[k] = 1'b1;
    end
    repeat (4) cyc();
    for (int k = 0; k < NU; k++) outready_a[k] = 1'b0;

    // Asynchronous reset while FULL.
    for (int p = 0; p < 2; p++) begin
      invalid_a[0] = 1'b1; inctl_a[0] = 8'($urandom); indata_a[0] = $urandom;
      invalid_a[2] = 1'b1; inctl_a[2] = 8'($urandom); indata_a[2] = $urandom;
      cyc();
    end
    invalid_a[0] = 1'b0;
    invalid_a[2] = 1'b0;
    check("prereset inready", inready_a[0], 0);
    #2 rstn = 1'b0;
    #1;
    for (int k = 0; k < NU; k++) begin
      check($sformatf("u%0d async rst outvalid", k), outvalid_a[k], 0);
      check($sformatf("u%0d async rst inready", k), inready_a[k], 1);
      check($sformatf("u%0d async rst dropcnt", k), dropcnt_a[k], 0);
      check($sformatf("u%0d async rst outctl", k), outctl_a[k], 0);
      check($sformatf("u%0d async rst outdata", k), outdata_a[k], 0);
    end
    @(posedge clk);
    #1 rstn = 1'b1;
    cyc();
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
